uart_tx_stream: RTL

//  Parametrised UART transmitter with a byte-stream input FIFO. Replaces the single-shot

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_sync_fifo.sv | 65 ++++++
 rtl/uart_tx_stream.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states, standard
// baud divisor and the parity bit helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // 27 MHz reference clock divided down to 115200 baud
    localparam int CLK_DIV_115200_27M = 234;

    // Turns the XOR of all data bits into the transmitted parity bit
    function automatic logic parity_bit(input logic data_xor, input parity_e mode);
        logic bit_s;
        case (mode)
            PAR_ODD:  bit_s = ~data_xor;
            PAR_EVEN: bit_s = data_xor;
            default:  bit_s = 1'b1;
        endcase
        return bit_s;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO. Writes when full and reads when empty are
// dropped internally, so callers may hold wr_en/rd_en without guarding.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             do_wr_s;
    logic             do_rd_s;

    assign full    = (level_r == FULL_LEVEL);
    assign empty   = (level_r == {(AW+1){1'b0}});
    assign level   = level_r;
    assign rd_data = mem_r[rd_ptr_r];
    assign do_wr_s = wr_en & ~full;
    assign do_rd_s = rd_en & ~empty;

    // Storage array; contents need no reset because level gates every read
    always_ff @(posedge CLK) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks occupancy
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Streaming UART transmitter: a valid/ready input FIFO feeding a framer that
// sends start, LSB-first data, optional parity and stop bits with no idle gap
// between queued words.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_DIVIDE = CLK_DIV_115200_27M,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [DATA_BITS-1:0]        IN_DATA,
    input  logic                        IN_VALID,
    output logic                        IN_READY,
    output logic                        TX,
    output logic                        TX_BUSY,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);

    localparam int BAUD_W = $clog2(CLK_DIVIDE);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIVIDE - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam parity_e PAR_MODE = (PARITY == 1) ? PAR_ODD :
                                   (PARITY == 2) ? PAR_EVEN : PAR_NONE;
    localparam bit HAS_PARITY = (PARITY != 0);

    tx_state_e            state_r, state_nxt_s;
    logic [BAUD_W-1:0]    baud_r, baud_nxt_s;
    logic [3:0]           bit_idx_r, bit_idx_nxt_s;
    logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
    logic                 par_acc_r, par_acc_nxt_s;
    logic                 tx_r, tx_nxt_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 full_s;
    logic                 empty_s;
    logic [DATA_BITS-1:0] head_s;
    logic                 baud_term_s;
    logic                 data_last_s;
    logic                 stop_last_s;

    assign IN_READY    = ~full_s;
    assign push_s      = IN_VALID & ~full_s;
    assign TX          = tx_r;
    assign TX_BUSY     = (state_r != TX_IDLE);
    assign baud_term_s = (baud_r == BAUD_LAST);
    assign data_last_s = (bit_idx_r == DATA_LAST);
    assign stop_last_s = (bit_idx_r == STOP_LAST);

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (push_s),
        .wr_data (IN_DATA),
        .rd_en   (pop_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (FIFO_LEVEL)
    );

    // FSM state register; reset abandons any frame in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= TX_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: every serial bit advances only on the baud terminal count
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            TX_IDLE: begin
                if (!empty_s) state_nxt_s = TX_START;
                else          state_nxt_s = TX_IDLE;
            end
            TX_START: begin
                if (baud_term_s) state_nxt_s = TX_DATA;
                else             state_nxt_s = TX_START;
            end
            TX_DATA: begin
                if (baud_term_s && data_last_s) state_nxt_s = HAS_PARITY ? TX_PARITY : TX_STOP;
                else                            state_nxt_s = TX_DATA;
            end
            TX_PARITY: begin
                if (baud_term_s) state_nxt_s = TX_STOP;
                else             state_nxt_s = TX_PARITY;
            end
            TX_STOP: begin
                if (baud_term_s && stop_last_s) state_nxt_s = empty_s ? TX_IDLE : TX_START;
                else                            state_nxt_s = TX_STOP;
            end
            default: state_nxt_s = TX_IDLE;
        endcase
    end

    // Output/datapath decode: FIFO pop, next TX level, shift, parity and counters
    always_comb begin
        pop_s         = 1'b0;
        tx_nxt_s      = tx_r;
        shift_nxt_s   = shift_r;
        bit_idx_nxt_s = bit_idx_r;
        par_acc_nxt_s = par_acc_r;
        baud_nxt_s    = baud_term_s ? {BAUD_W{1'b0}} : (baud_r + BAUD_W'(1));
        case (state_r)
            TX_IDLE: begin
                baud_nxt_s    = {BAUD_W{1'b0}};
                bit_idx_nxt_s = 4'd0;
                if (!empty_s) begin
                    pop_s         = 1'b1;
                    shift_nxt_s   = head_s;
                    par_acc_nxt_s = 1'b0;
                    tx_nxt_s      = 1'b0;
                end else begin
                    tx_nxt_s = 1'b1;
                end
            end
            TX_START: begin
                if (baud_term_s) begin
                    tx_nxt_s      = shift_r[0];
                    par_acc_nxt_s = par_acc_r ^ shift_r[0];
                    shift_nxt_s   = shift_r >> 1;
                    bit_idx_nxt_s = 4'd0;
                end else begin
                    tx_nxt_s = 1'b0;
                end
            end
            TX_DATA: begin
                if (baud_term_s && data_last_s) begin
                    bit_idx_nxt_s = 4'd0;
                    if (HAS_PARITY) tx_nxt_s = parity_bit(par_acc_r, PAR_MODE);
                    else            tx_nxt_s = 1'b1;
                end else if (baud_term_s) begin
                    bit_idx_nxt_s = bit_idx_r + 4'd1;
                    tx_nxt_s      = shift_r[0];
                    par_acc_nxt_s = par_acc_r ^ shift_r[0];
                    shift_nxt_s   = shift_r >> 1;
                end else begin
                    tx_nxt_s = tx_r;
                end
            end
            TX_PARITY: begin
                if (baud_term_s) begin
                    tx_nxt_s      = 1'b1;
                    bit_idx_nxt_s = 4'd0;
                end else begin
                    tx_nxt_s = tx_r;
                end
            end
            TX_STOP: begin
                if (baud_term_s && stop_last_s) begin
                    bit_idx_nxt_s = 4'd0;
                    if (!empty_s) begin
                        pop_s         = 1'b1;
                        shift_nxt_s   = head_s;
                        par_acc_nxt_s = 1'b0;
                        tx_nxt_s      = 1'b0;
                    end else begin
                        tx_nxt_s = 1'b1;
                    end
                end else if (baud_term_s) begin
                    bit_idx_nxt_s = bit_idx_r + 4'd1;
                    tx_nxt_s      = 1'b1;
                end else begin
                    tx_nxt_s = 1'b1;
                end
            end
            default: begin
                tx_nxt_s      = 1'b1;
                baud_nxt_s    = {BAUD_W{1'b0}};
                bit_idx_nxt_s = 4'd0;
            end
        endcase
    end

    // Datapath registers; TX returns high on reset so the line idles
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_r      <= 1'b1;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= 4'd0;
            shift_r   <= {DATA_BITS{1'b0}};
            par_acc_r <= 1'b0;
        end else begin
            tx_r      <= tx_nxt_s;
            baud_r    <= baud_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
            par_acc_r <= par_acc_nxt_s;
        end
    end

endmodule
